// File: rtl/muldiv_unit.sv
// Iterative RV64M-style multiply/divide engine with valid/ready request and response ports.
// Shift-add multiply retires MUL_BITS per cycle; restoring divide retires one quotient bit.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_word,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy
);

  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam logic [2:0]  OpMul = 3'd0;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               word_q, word_d, neg_q, neg_d, nega_q, nega_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0]   result_q, result_d;

  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r       = {WIDTH{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r       = '0;
    r[31:0] = v[31:0];
    return r;
  endfunction

  // Accept-time decode: operands are widened to WIDTH so one datapath serves both modes.
  logic             word_in, sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf, special;
  logic [WIDTH-1:0] a_ext, b_ext, mag_a, mag_b, min_val, special_res;

  always_comb begin
    word_in  = (WIDTH > 32) && req_word && ((req_op == OpMul) || req_op[2]);
    sgn_a    = req_op inside {3'd1, 3'd2, 3'd4, 3'd6};
    sgn_b    = req_op inside {3'd1, 3'd4, 3'd6};
    a_ext    = req_a;
    b_ext    = req_b;
    if (word_in) begin
      a_ext = sgn_a ? sext32(req_a) : zext32(req_a);
      b_ext = sgn_b ? sext32(req_b) : zext32(req_b);
    end
    neg_a    = sgn_a && a_ext[WIDTH-1];
    neg_b    = sgn_b && b_ext[WIDTH-1];
    mag_a    = neg_a ? -a_ext : a_ext;
    mag_b    = neg_b ? -b_ext : b_ext;
    min_val  = word_in ? ~WIDTH'(32'h7fff_ffff) : {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = sgn_b && (a_ext == min_val) && (b_ext == '1);
    special  = req_op[2] && (div_zero || ovf);
    if (div_zero) begin
      special_res = req_op[1] ? (word_in ? sext32(req_a) : req_a) : '1;
    end else begin
      special_res = req_op[1] ? '0 : a_ext;
    end
  end

  // One iteration step of each algorithm, plus the signed/word result it would finish with.
  logic [2*WIDTH-1:0] acc_nx, prod;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   rem_nx, quo_nx, q_fix, r_fix, q_or_r, mul_res, div_res;

  always_comb begin
    acc_nx = acc_q;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) acc_nx = acc_nx + (mcand_q << j);
    end
    prod = neg_q ? -acc_nx : acc_nx;
    if (word_q) begin
      mul_res = sext32(prod[WIDTH-1:0]);
    end else begin
      mul_res = (op_q == OpMul) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    q_fix   = neg_q ? -quo_nx : quo_nx;
    r_fix   = nega_q ? -rem_nx : rem_nx;
    q_or_r  = op_q[1] ? r_fix : q_fix;
    div_res = word_q ? sext32(q_or_r) : q_or_r;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          op_d     = req_op;
          word_d   = word_in;
          neg_d    = neg_a ^ neg_b;
          nega_d   = neg_a;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          rem_d    = '0;
          quo_d    = word_in ? (mag_a << (WIDTH - 32)) : mag_a;
          dvsr_d   = mag_b;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else if (req_op[2]) begin
            cnt_d   = word_in ? CntW'(32) : CntW'(WIDTH);
            state_d = StDiv;
          end else begin
            cnt_d   = word_in ? CntW'(32 / MUL_BITS) : CntW'(WIDTH / MUL_BITS);
            state_d = StMul;
          end
        end
      end
      StMul: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << MUL_BITS;
        mplier_d = mplier_q >> MUL_BITS;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = mul_res;
          state_d  = StDone;
        end
      end
      StDiv: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          result_d = div_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
    end
  end

  assign req_ready  = (state_q == StIdle) && !flush;
  assign resp_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign resp_data  = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model with latency bookkeeping,
// checked every cycle, plus directed cases with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic        m_busy, m_valid;
  int          m_left;
  logic [63:0] m_data;

  muldiv_unit #(.WIDTH(64), .MUL_BITS(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_word   (req_word),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic word_eff(input logic [2:0] op, input logic word);
    return word && (op == 3'd0 || op[2]);
  endfunction

  // Expected result straight from the RV64M arithmetic rules.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0]         x, y, r;
    logic signed [127:0] sa, sb, p;
    logic [127:0]        ua, ub, up;
    if (word_eff(op, word)) begin
      x = a[31:0];
      y = b[31:0];
      case (op)
        3'd0: r = x * y;
        3'd4: if (y == 0) r = '1;
              else if (x == 32'h8000_0000 && y == '1) r = x;
              else r = $signed(x) / $signed(y);
        3'd5: r = (y == 0) ? '1 : x / y;
        3'd6: if (y == 0) r = x;
              else if (x == 32'h8000_0000 && y == '1) r = '0;
              else r = $signed(x) % $signed(y);
        default: r = (y == 0) ? x : x % y;
      endcase
      return sx32(r);
    end
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    case (op)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * $signed(ub); return p[127:64]; end
      3'd3: begin up = ua * ub; return up[127:64]; end
      3'd4: if (b == 0) return '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) return '0;
            else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from accept edge to the first edge that samples resp_valid high.
  function automatic int ref_lat(input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
    int   n;
    logic we, zero, ovf;
    we = word_eff(op, word);
    n  = we ? 32 : 64;
    if (!op[2]) return n / 4 + 1;
    zero = we ? (b[31:0] == 0) : (b == 0);
    ovf  = (op == 3'd4 || op == 3'd6) &&
           (we ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
               : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 1 : n + 1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_data  <= '0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_data  <= ref_result(req_op, req_word, req_a, req_b);
        m_left  <= ref_lat(req_op, req_word, req_a, req_b) - 1;
        m_valid <= (ref_lat(req_op, req_word, req_a, req_b) == 1);
      end
    end else if (!m_valid) begin
      if (m_left == 1) m_valid <= 1'b1;
      m_left <= m_left - 1;
    end else if (resp_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst resp_data", resp_data, 64'd0);
    end else begin
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("req_ready", 64'(req_ready), 64'(!m_busy && !flush));
      if (m_valid) chk("resp_data", resp_data, m_data);
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 200);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int k;
    req_op = op; req_word = word; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    wait_valid(k);
    chk({name, " latency"}, 64'(k), 64'(exp_lat));
    chk({name, " data"}, resp_data, exp);
    chk({name, " model"}, m_data, exp);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int k, nv;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    run_op("mul", 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 17);
    run_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 17);
    run_op("mulh", 3'd1, 1'b0, '1, '1, 64'd0, 17);
    run_op("mulhsu", 3'd2, 1'b0, '1, 64'd1, '1, 17);
    run_op("div0", 3'd4, 1'b0, 64'd7, 64'd0, '1, 1);
    run_op("remu0", 3'd7, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run_op("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("divuw", 3'd5, 1'b1, 64'h1_0000_0010, 64'd3, 64'd5, 33);
    run_op("divw ovf", 3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw", 3'd6, 1'b1, -64'd7, 64'd2, '1, 33);
    run_op("mulw", 3'd0, 1'b1, 64'h5_0001_0000, 64'h7_0001_0000, 64'd0, 9);

    // Back-pressure: result held while the consumer stalls.
    resp_ready = 1'b0;
    req_op = 3'd4; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(k);
    chk("bp latency", 64'(k), 64'd65);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp data", resp_data, 64'd14);
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp valid", 64'(resp_valid), 64'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp ready after", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Flush mid-divide with a competing request in the same cycle.
    req_op = 3'd4; req_a = 64'd1000; req_b = 64'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_a = 64'd6; req_b = 64'd7;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush req_ready", 64'(req_ready), 64'd1);
    nv = 0;
    repeat (80) begin
      @(negedge clk);
      if (resp_valid) nv++;
    end
    chk("flush no resp", 64'(nv), 64'd0);
    @(posedge clk); #1;
    run_op("mul after flush", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 17);

    // Asynchronous reset mid-multiply.
    req_op = 3'd0; req_a = 64'd6; req_b = 64'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst valid", 64'(resp_valid), 64'd0);
    chk("async rst data", resp_data, 64'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    run_op("mul after reset", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 17);

    // Random traffic; operands keep changing so only accept-time values may matter.
    for (int c = 0; c < 6000; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_op     = 3'($urandom_range(0, 7));
      req_word   = 1'($urandom_range(0, 1));
      req_a      = rnd();
      req_b      = rnd();
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    k = 0;
    while (m_busy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
